// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: streaming bus for logic_unit_pipe.
// Carries the valid/ready operand stream into the block and the flagged result stream out.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : logic_unit_pipe side (drives in_ready, out_*)
// Parameter WIDTH sets the operand/result width.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_parity;

    modport master (
        output in_valid, in_a, in_b, in_op, in_chain, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_chain, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with zero/parity flags.
// Stage 1 registers the operands, stage 2 computes and registers the result, so a beat
// accepted at edge N is presented after edge N+1. Full valid/ready backpressure,
// one beat per cycle sustained.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, discards all in-flight beats
//   bus  - logic_unit_pipe_if.slave: in_valid/in_ready/in_a/in_b/in_op/in_chain,
//          out_valid/out_ready/out_result/out_zero/out_parity
// Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 NOT B.
// Optional macro LGU_CHAIN_EN: a beat with in_chain=1 takes the previous beat's result
// (last_res register) as operand A. Without it in_chain is ignored.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    logic_unit_pipe_if.slave bus
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
`ifdef LGU_CHAIN_EN
    logic             r_s1_chain;
    logic [WIDTH-1:0] r_last_res;
`endif

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_zero;
    logic             r_out_parity;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_result;

    // S2 can take a new beat when it is empty or its beat leaves this cycle.
    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_in_xfer  = bus.in_valid && w_in_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_zero   = r_out_zero;
    assign bus.out_parity = r_out_parity;

`ifdef LGU_CHAIN_EN
    // last_res always holds the result of the beat ahead of S1, even while it waits in S2.
    assign w_op_a = r_s1_chain ? r_last_res : r_s1_a;
`else
    assign w_op_a = r_s1_a;
`endif

    always_comb begin
        w_result = '0;
        unique case (r_s1_op)
            3'd0: w_result = w_op_a & r_s1_b;
            3'd1: w_result = w_op_a | r_s1_b;
            3'd2: w_result = ~(w_op_a & r_s1_b);
            3'd3: w_result = ~(w_op_a | r_s1_b);
            3'd4: w_result = w_op_a ^ r_s1_b;
            3'd5: w_result = ~(w_op_a ^ r_s1_b);
            3'd6: w_result = ~w_op_a;
            3'd7: w_result = ~r_s1_b;
        endcase
    end

    // Stage 1: operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
`ifdef LGU_CHAIN_EN
            r_s1_chain <= 1'b0;
`endif
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= bus.in_a;
            r_s1_b     <= bus.in_b;
            r_s1_op    <= bus.in_op;
`ifdef LGU_CHAIN_EN
            r_s1_chain <= bus.in_chain;
`endif
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result and flags. Data holds when the stage drains to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_parity <= 1'b0;
`ifdef LGU_CHAIN_EN
            r_last_res   <= '0;
`endif
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= w_result;
                r_out_zero   <= ~|w_result;
                r_out_parity <= ^w_result;
`ifdef LGU_CHAIN_EN
                r_last_res   <= w_result;
`endif
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
    localparam int unsigned WIDTH = 8;
`ifdef LGU_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             parity;
        int               acc_cyc;
        bit               lat_chk;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               n_acc    = 0;
    bit               lat_mode = 1'b0;
    bit               rand_on  = 1'b0;
    logic [WIDTH-1:0] m_last_res = '0;

    // Truth table per opcode, indexed by {a_bit, b_bit}.
    logic [3:0] tt_tab [8];
    initial begin
        tt_tab[0] = 4'b1000; tt_tab[1] = 4'b1110; tt_tab[2] = 4'b0111; tt_tab[3] = 4'b0001;
        tt_tab[4] = 4'b0110; tt_tab[5] = 4'b1001; tt_tab[6] = 4'b0011; tt_tab[7] = 4'b0101;
    end

    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        tt = tt_tab[op];
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic ref_parity(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) n++;
        return (n % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on each output transfer and checks hold stability.
    bit               held_v    = 1'b0;
    logic [WIDTH+1:0] held_data = '0;
    bit               new_beat  = 1'b1;
    int               first_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_v   = 1'b0;
            new_beat = 1'b1;
        end else begin
            if (held_v) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.out_result, bus.out_zero, bus.out_parity}),
                      32'(held_data));
            end
            if (bus.out_valid && new_beat) begin
                first_cyc = cyc;
                new_beat  = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", bus.out_result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 32'(bus.out_result), 32'(e.res));
                    check("zero", 32'(bus.out_zero), 32'(e.zero));
                    check("parity", 32'(bus.out_parity), 32'(e.parity));
                    if (e.lat_chk) check("latency", 32'(first_cyc - e.acc_cyc), 32'd2);
                end
                new_beat = 1'b1;
            end
            held_v    = bus.out_valid && !bus.out_ready;
            held_data = {bus.out_result, bus.out_zero, bus.out_parity};
        end
    end

    // All driver tasks start and end at posedge + 1.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                        input logic chain, input bit use_exp, input logic [WIDTH-1:0] exp_res,
                        output int waits);
        exp_t             e;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] r;
        bit               acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_chain = chain;
        waits        = 0;
        while (!acc && waits <= 100) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            else waits++;
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            opa        = (CHAIN && chain) ? m_last_res : a;
            r          = ref_op(opa, b, op);
            m_last_res = r;
            e.res      = use_exp ? exp_res : r;
            e.zero     = (e.res == '0);
            e.parity   = ref_parity(e.res);
            e.acc_cyc  = cyc;
            e.lat_chk  = lat_mode;
            sb_q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_chain = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        bus.in_valid = 1'b0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               w;
        logic [WIDTH-1:0] op_exp [8];
        int               base;
        op_exp[0] = 8'h05; op_exp[1] = 8'hAF; op_exp[2] = 8'hFA; op_exp[3] = 8'h50;
        op_exp[4] = 8'hAA; op_exp[5] = 8'h55; op_exp[6] = 8'h5A; op_exp[7] = 8'hF0;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_chain  = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        check("rst_out_parity", 32'(bus.out_parity), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single XOR beat with explicit latency probe.
        lat_mode = 1'b1;
        send(8'hF0, 8'h3C, 3'd4, 1'b0, 1'b1, 8'hCC, w);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("single_not_yet", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_result", 32'(bus.out_result), 32'hCC);
        @(posedge clk);
        #1;
        drain();

        // All opcodes back-to-back, no bubbles.
        for (int op = 0; op < 8; op++) begin
            send(8'hA5, 8'h0F, 3'(op), 1'b0, 1'b1, op_exp[op], w);
            check("opcode_no_wait", 32'(w), 32'd0);
        end
        drain();

        // Flags.
        send(8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1, 8'hFF, w);
        send(8'hFF, 8'hFF, 3'd4, 1'b0, 1'b1, 8'h00, w);
        drain();
        lat_mode = 1'b0;

        // Backpressure: 5-cycle stall in the middle of 10 beats.
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)), 1'b0,
                         1'b0, '0, w);
                bus.in_valid = 1'b0;
            end
            begin
                int t = 0;
                while (n_acc < base + 3 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_all_accepted", 32'(n_acc - base), 32'd10);

        // Reset with both stages full and a third beat waiting.
        bus.out_ready = 1'b0;
        send(8'h11, 8'h22, 3'd0, 1'b0, 1'b0, '0, w);
        send(8'h33, 8'h44, 3'd1, 1'b0, 1'b0, '0, w);
        bus.in_a     = 8'h55;
        bus.in_b     = 8'h66;
        bus.in_op    = 3'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        sb_q.delete();
        m_last_res   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_result", 32'(bus.out_result), 32'd0);
        check("midrst_out_zero", 32'(bus.out_zero), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(6);

        // Chain, back-to-back then with a stall between the beats.
        send(8'h0F, 8'h00, 3'd1, 1'b0, 1'b1, 8'h0F, w);
        send(8'hAA, 8'h3C, 3'd4, 1'b1, 1'b1, CHAIN ? 8'h33 : 8'h96, w);
        drain();
        bus.out_ready = 1'b0;
        send(8'h0F, 8'h00, 3'd1, 1'b0, 1'b1, 8'h0F, w);
        send(8'hAA, 8'h3C, 3'd4, 1'b1, 1'b1, CHAIN ? 8'h33 : 8'h96, w);
        idle(3);
        bus.out_ready = 1'b1;
        drain();

        // Random traffic with random backpressure.
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'b0, '0, w);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
                bus.in_valid = 1'b0;
                rand_on      = 1'b0;
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
